// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port data-memory arbiter with m1 starvation guard and read-data return routing
module dmem_arbiter #(
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic        m0_req,
   input  logic        m0_we,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   output logic        m0_gnt,
   output logic        m0_rvalid,
   output logic [31:0] m0_rdata,
   input  logic        m1_req,
   input  logic        m1_we,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   output logic        m1_gnt,
   output logic        m1_rvalid,
   output logic [31:0] m1_rdata,
   output logic        mem_en,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, OWN0, OWN1} own_t;

   localparam logic [3:0] SMAX = 4'(STARVE_MAX);

   own_t        state, state_nxt;
   logic [3:0]  starve_cnt;
   logic        rd_pend;
   logic [31:0] m0_rdata_q, m1_rdata_q;
   logic        m1_forced;

   always_comb begin
      m1_forced = 1'b0;
      m0_gnt    = 1'b0;
      m1_gnt    = 1'b0;
      state_nxt = IDLE;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = 32'h0;
      mem_wdata = 32'h0;
      m0_rvalid = 1'b0;
      m1_rvalid = 1'b0;

      m1_forced = (starve_cnt == SMAX);
      m0_gnt    = m0_req && !(m1_req && m1_forced);
      m1_gnt    = m1_req && !m0_gnt;

      if (m0_gnt)
         state_nxt = OWN0;
      else if (m1_gnt)
         state_nxt = OWN1;

      // Grants stay live in reset; only the memory strobe is suppressed.
      if (resetn && m0_gnt) begin
         mem_en    = 1'b1;
         mem_we    = m0_we;
         mem_addr  = m0_addr;
         mem_wdata = m0_wdata;
      end else if (resetn && m1_gnt) begin
         mem_en    = 1'b1;
         mem_we    = m1_we;
         mem_addr  = m1_addr;
         mem_wdata = m1_wdata;
      end

      m0_rvalid = rd_pend && (state == OWN0);
      m1_rvalid = rd_pend && (state == OWN1);
   end

   // Returned data bypasses straight through in the delivery cycle, then is held.
   assign m0_rdata = m0_rvalid ? mem_rdata : m0_rdata_q;
   assign m1_rdata = m1_rvalid ? mem_rdata : m1_rdata_q;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state      <= IDLE;
         rd_pend    <= 1'b0;
         starve_cnt <= 4'd0;
         m0_rdata_q <= 32'h0;
         m1_rdata_q <= 32'h0;
      end else begin
         state   <= state_nxt;
         rd_pend <= (m0_gnt && !m0_we) || (m1_gnt && !m1_we);

         if (m1_gnt || !m1_req)
            starve_cnt <= 4'd0;
         else if (starve_cnt != SMAX)
            starve_cnt <= starve_cnt + 4'd1;

         if (m0_rvalid)
            m0_rdata_q <= mem_rdata;
         if (m1_rvalid)
            m1_rdata_q <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

   localparam int SM = 4;

   logic        clock = 1'b0;
   logic        resetn;
   logic        m0_req, m0_we, m1_req, m1_we;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
   logic [31:0] m0_rdata, m1_rdata;
   logic        mem_en, mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   int errors = 0;
   int checks = 0;

   int          exp_cnt;
   int          pend;
   logic [31:0] last0, last1;

   dmem_arbiter #(.STARVE_MAX(SM)) dut (
      .clock(clock), .resetn(resetn),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic rn,
                        input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                        input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                        input logic [31:0] rd);
      @(negedge clock);
      resetn   = rn;
      m0_req   = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
      m1_req   = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
      mem_rdata = rd;
      #1;
   endtask

   // Reference: decide the winner from the priority rules, predict every output, advance the model.
   task automatic model_step();
      int          g;
      logic        e_en, e_we;
      logic [31:0] e_addr, e_wdata;
      if (!resetn) begin
         exp_cnt = 0; pend = -1; last0 = 0; last1 = 0;
      end
      g = -1;
      if (m0_req && m1_req)
         g = (exp_cnt >= SM) ? 1 : 0;
      else if (m0_req)
         g = 0;
      else if (m1_req)
         g = 1;

      e_en = resetn && (g >= 0);
      e_we = 0; e_addr = 0; e_wdata = 0;
      if (e_en && g == 0) begin e_we = m0_we; e_addr = m0_addr; e_wdata = m0_wdata; end
      if (e_en && g == 1) begin e_we = m1_we; e_addr = m1_addr; e_wdata = m1_wdata; end

      chk("m0_gnt", m0_gnt, g == 0);
      chk("m1_gnt", m1_gnt, g == 1);
      chk("mem_en", mem_en, e_en);
      chk("mem_we", mem_we, e_we);
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_wdata", mem_wdata, e_wdata);
      chk("m0_rvalid", m0_rvalid, pend == 0);
      chk("m1_rvalid", m1_rvalid, pend == 1);
      chk("m0_rdata", m0_rdata, (pend == 0) ? mem_rdata : last0);
      chk("m1_rdata", m1_rdata, (pend == 1) ? mem_rdata : last1);

      if (resetn) begin
         if (pend == 0) last0 = mem_rdata;
         if (pend == 1) last1 = mem_rdata;
         if (m1_req && g != 1)
            exp_cnt = (exp_cnt + 1 > SM) ? SM : exp_cnt + 1;
         else
            exp_cnt = 0;
         pend = -1;
         if (g == 0 && !m0_we) pend = 0;
         if (g == 1 && !m1_we) pend = 1;
      end
      @(posedge clock);
   endtask

   task automatic idle();
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, $urandom);
      model_step();
   endtask

   initial begin
      exp_cnt = 0; pend = -1; last0 = 0; last1 = 0;
      resetn = 0;
      m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
      m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
      mem_rdata = 0;

      // Reset: grant follows request but the memory strobe stays off.
      drive(0, 1, 1, 32'h44, 32'h55, 0, 0, 0, 0, 32'hdead_beef);
      chk("reset_mem_en", mem_en, 1'b0);
      chk("reset_m0_gnt", m0_gnt, 1'b1);
      chk("reset_m0_rdata", m0_rdata, 32'h0);
      model_step();
      idle();

      // m0 read returns data one cycle later.
      drive(1, 1, 0, 32'h10, 0, 0, 0, 0, 0, 32'h0);
      chk("rd0_gnt", m0_gnt, 1'b1);
      chk("rd0_addr", mem_addr, 32'h10);
      model_step();
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1234_5678);
      chk("rd0_rvalid", m0_rvalid, 1'b1);
      chk("rd0_rdata", m0_rdata, 32'h1234_5678);
      chk("rd0_m1_rvalid", m1_rvalid, 1'b0);
      model_step();
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0bad_0bad);
      chk("rd0_hold", m0_rdata, 32'h1234_5678);
      model_step();

      // Continuous contention: m1 wins every fifth cycle.
      for (int i = 0; i < 10; i++) begin
         drive(1, 1, 1, 32'h100 + i, i, 1, 1, 32'h200 + i, i, 0);
         chk("starve_m1_gnt", m1_gnt, (i % 5) == 4);
         model_step();
      end
      idle();

      // m1 write with m0 idle.
      drive(1, 0, 0, 0, 0, 1, 1, 32'h80, 32'ha5a5_a5a5, 0);
      chk("wr1_en", mem_en, 1'b1);
      chk("wr1_we", mem_we, 1'b1);
      chk("wr1_addr", mem_addr, 32'h80);
      chk("wr1_wdata", mem_wdata, 32'ha5a5_a5a5);
      model_step();
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h7777_7777);
      chk("wr1_no_rvalid", m1_rvalid, 1'b0);
      model_step();

      // Alternating reads, no bubble.
      drive(1, 1, 0, 32'h20, 0, 0, 0, 0, 0, 0);
      model_step();
      drive(1, 0, 0, 0, 0, 1, 0, 32'h24, 0, 32'haaaa_0000);
      chk("alt_m0_rvalid", m0_rvalid, 1'b1);
      chk("alt_m0_rdata", m0_rdata, 32'haaaa_0000);
      chk("alt_m1_gnt", m1_gnt, 1'b1);
      model_step();
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'hbbbb_1111);
      chk("alt_m1_rvalid", m1_rvalid, 1'b1);
      chk("alt_m1_rdata", m1_rdata, 32'hbbbb_1111);
      chk("alt_m0_rvalid_off", m0_rvalid, 1'b0);
      model_step();

      // Reset during the return cycle of an m1 read discards it.
      drive(1, 0, 0, 0, 0, 1, 0, 32'h30, 0, 0);
      model_step();
      drive(0, 1, 0, 32'h34, 0, 0, 0, 0, 0, 32'hcccc_cccc);
      chk("rst_m1_rvalid", m1_rvalid, 1'b0);
      chk("rst_mem_en", mem_en, 1'b0);
      model_step();
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'hdddd_dddd);
      chk("rst_after_rvalid", m1_rvalid, 1'b0);
      chk("rst_after_rdata", m1_rdata, 32'h0);
      model_step();

      // m1 gives up after three denials; a new request starts counting from zero.
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, 1, 32'h40, 0, 1, 0, 32'h50, 0, 0);
         model_step();
      end
      drive(1, 1, 1, 32'h40, 0, 0, 0, 0, 0, 0);
      model_step();
      for (int i = 0; i < 5; i++) begin
         drive(1, 1, 1, 32'h40, 0, 1, 1, 32'h50, 0, 0);
         chk("restart_m1_gnt", m1_gnt, i == 4);
         model_step();
      end
      idle();

      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(0, 49) != 0),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
               1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)), $urandom, $urandom,
               $urandom);
         model_step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4, is the number of consecutive cycles m1 may be denied while requesting before it is force-granted; legal range 1..15.
REQ-002 clock  in  1  system clock; all state updates on the rising edge.
REQ-003 resetn  in  1  reset; one clock; asynchronous, active-low.
REQ-004 m0_req  in  1  CPU port access request, held high until granted.
REQ-005 m0_we  in  1  CPU port write (1) / read (0).
REQ-006 m0_addr  in  32  CPU port byte address.
REQ-007 m0_wdata  in  32  CPU port write data.
REQ-008 m0_gnt  out  1  CPU port granted this cycle.
REQ-009 m0_rvalid  out  1  CPU port read data valid.
REQ-010 m0_rdata  out  32  CPU port read data.
REQ-011 m1_req, m1_we, m1_addr[31:0], m1_wdata[31:0], m1_gnt, m1_rvalid, m1_rdata[31:0] SHALL mirror the m0 ports for the second requester (DMA/IO scan engine).
REQ-012 mem_en  out  1  shared data-memory/IO access strobe.
REQ-013 mem_we  out  1  shared write enable.
REQ-014 mem_addr  out  32  shared address.
REQ-015 mem_wdata  out  32  shared write data.
REQ-016 mem_rdata  in  32  shared read data, valid one cycle after a read access (synchronous memory).

Function
REQ-017 At most one of m0_gnt, m1_gnt SHALL be high in any cycle; the grant is combinational from the reqs and the registered starvation count.
REQ-018 Default priority: m0 wins when both request, unless starve_cnt == STARVE_MAX, in which case m1 wins.
REQ-019 starve_cnt (4 bits) SHALL increment when m1_req && !m1_gnt, clear when m1_gnt or !m1_req, and saturate at STARVE_MAX.
REQ-020 When either grant is high: mem_en=1 and mem_we/mem_addr/mem_wdata equal the granted port's fields in the same cycle; with no grant: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-021 A granted read SHALL register owner (0/1) in a 1-bit rd_owner register plus a rd_pend flag; in the next cycle the owner's rvalid is 1 and its rdata equals mem_rdata; the other port's rvalid is 0.
REQ-022 rdata of each port SHALL be registered and hold the last delivered value until the next read for that port completes.
REQ-023 Writes SHALL produce no rvalid; a write is complete in its grant cycle.
REQ-024 Back-to-back reads from alternating ports SHALL each deliver data exactly one cycle after their grant with no bubble (throughput one access per cycle).
REQ-025 A request is considered accepted only in a cycle where its gnt is high; a requester dropping req before gnt SHALL leave no side effects.
REQ-026 Owner state machine: IDLE (no access last cycle), OWN0, OWN1; next state = OWN0 on m0_gnt, OWN1 on m1_gnt, else IDLE; rvalid routing uses this state qualified by rd_pend.

Reset
REQ-027 While resetn=0: starve_cnt=0, state=IDLE, rd_pend=0, m0_rvalid=m1_rvalid=0, m0_rdata=m1_rdata=0; grants follow REQ-017..018 from the reset counter value but mem_en SHALL be forced 0.
REQ-028 Reset asserted with a read in flight SHALL discard it: no rvalid after resetn rises.

Verification
REQ-029 m0 read addr 0x10, memory returns 0x12345678 -> m0_gnt in cycle 0, m0_rvalid=1, m0_rdata=0x12345678 in cycle 1, m1_rvalid=0.
REQ-030 m0 and m1 request continuously, STARVE_MAX=4 -> m0 granted 4 cycles, m1 granted on cycle 5, pattern repeats every 5 cycles.
REQ-031 m1 write addr 0x80 data 0xA5A5A5A5 with m0 idle -> same cycle mem_en=1, mem_we=1, mem_addr=0x80, mem_wdata=0xA5A5A5A5; no rvalid next cycle.
REQ-032 Alternating reads m0 (cycle 0), m1 (cycle 1) -> m0_rvalid cycle 1, m1_rvalid cycle 2, data routed to the correct port.
REQ-033 resetn pulsed low during cycle after an m1 read grant -> m1_rvalid stays 0, starve_cnt=0, mem_en=0 while in reset.
REQ-034 m1 requests 3 cycles then drops req while m0 busy -> starve_cnt returns to 0; m1 later requesting restarts count from 0.
